pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and redirect-source encoding for the PC generator slice.
package pc_gen_pkg;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_RESET_VEC = 0;
  localparam int unsigned DEF_PC_STEP   = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_SEQ    = 3'd1,
    SRC_RET    = 3'd2,
    SRC_BRANCH = 3'd3,
    SRC_TRAP   = 3'd4
  } redirect_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push to a full stack overwrites the oldest entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_data_c_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q, wr_en;

  // ptr_q names the next free slot; the top lives one below it
  assign top_idx      = ptr_q - PTR_W'(1);
  assign top_data_c_o = mem_q[top_idx];
  assign empty_o      = empty_q;
  assign full_o       = full_q;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i && !empty_q) begin
      // pop-then-push collapses to replacing the top in place
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_q) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_q) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > branch > return > sequential, with a return-address stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter int unsigned     PC_STEP   = DEF_PC_STEP,
  parameter int unsigned     RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_halt,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_addr,
  input  logic            i_branch_en,
  input  logic [XLEN-1:0] i_branch_addr,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic            i_fetch_ready,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_npc,
  output logic            o_taken_branch,
  output logic            o_misalign,
  output logic            o_ras_underflow
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_STEP - 1);
  localparam logic [XLEN-1:0] RESET_NPC  = RESET_VEC + STEP;

  logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d, tgt;
  logic            taken_q, taken_d, misalign_q, misalign_d, uflow_q, uflow_d;
  logic            valid_q;
  logic            fire, ras_push, ras_pop, ras_empty, ras_full_unused;
  logic [XLEN-1:0] ras_top;
  redirect_src_e   src;

  assign fire = valid_q && i_fetch_ready && !i_halt;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i        (i_clk),
    .rst_ni       (i_rst),
    .push_i       (ras_push),
    .pop_i        (ras_pop),
    .push_data_i  (npc_q),
    .top_data_c_o (ras_top),
    .empty_o      (ras_empty),
    .full_o       (ras_full_unused)
  );

  // Select the winning update source, then derive next PC state from it
  always_comb begin
    src        = SRC_NONE;
    tgt        = '0;
    ras_pop    = 1'b0;
    ras_push   = 1'b0;
    pc_d       = pc_q;
    npc_d      = npc_q;
    taken_d    = taken_q;
    misalign_d = 1'b0;
    uflow_d    = 1'b0;

    if (i_trap_en) begin
      src = SRC_TRAP;
      tgt = i_trap_addr;
    end else if (i_branch_en && !i_halt) begin
      src = SRC_BRANCH;
      tgt = i_branch_addr;
    end else if (fire && i_ret && !ras_empty) begin
      src     = SRC_RET;
      tgt     = ras_top;
      ras_pop = 1'b1;
    end else if (fire) begin
      src     = SRC_SEQ;
      uflow_d = i_ret;
    end

    ras_push = fire && i_call && ((src == SRC_RET) || (src == SRC_SEQ));

    case (src)
      SRC_TRAP, SRC_BRANCH, SRC_RET: begin
        pc_d       = tgt & ~ALIGN_MASK;
        npc_d      = pc_d + STEP;
        taken_d    = 1'b1;
        misalign_d = |(tgt & ALIGN_MASK);
      end
      SRC_SEQ: begin
        pc_d    = npc_q;
        npc_d   = npc_q + STEP;
        taken_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q       <= RESET_VEC;
      npc_q      <= RESET_NPC;
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      uflow_q    <= 1'b0;
      valid_q    <= 1'b1;
    end else begin
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      taken_q    <= taken_d;
      misalign_q <= misalign_d;
      uflow_q    <= uflow_d;
      valid_q    <= 1'b1;
    end
  end

  assign o_fetch_valid   = valid_q;
  assign o_pc            = pc_q;
  assign o_npc           = npc_q;
  assign o_taken_branch  = taken_q;
  assign o_misalign      = misalign_q;
  assign o_ras_underflow = uflow_q;

endmodule
